// File: rtl/uart_bus_master_if.sv
// Byte-stream and bus-side signals of uart_bus_master, grouped for port connection.
// The master modport is the bridge's view; slave is the environment (UART + fabric).
interface uart_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_rx_ready;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic                  o_bus_req;
  logic                  o_bus_rnw;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wdata;
  logic                  i_bus_ack;
  logic [DATA_WIDTH-1:0] i_bus_rdata;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_bus_ack, i_bus_rdata,
    output o_rx_ready, o_tx_data, o_tx_valid, o_bus_req, o_bus_rnw, o_bus_addr, o_bus_wdata
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_bus_ack, i_bus_rdata,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_bus_req, o_bus_rnw, o_bus_addr, o_bus_wdata
  );
endinterface

// File: rtl/uart_bus_master.sv
// Serial-to-bus bridge: decodes 'W'/'R' byte frames, runs one bus transaction with a
// timeout, and streams the result ('K', read data, 'E' or '?') back out as bytes.
module uart_bus_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               n_rst,
  uart_bus_master_if.master bus
);
  localparam int unsigned AB = ADDR_WIDTH / 8;
  localparam int unsigned DB = DATA_WIDTH / 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspOk    = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h45;
  localparam logic [7:0] RspUnk   = 8'h3F;

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StBus, StResp} state_e;

  state_e                state_q, state_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  rx_fire, tx_fire;

  assign rx_fire = bus.i_rx_valid & rx_ready_q;
  assign tx_fire = (state_q == StResp) & bus.i_tx_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          byte_cnt_d = '0;
          if (bus.i_rx_data == CmdWrite) begin
            rnw_d   = 1'b0;
            state_d = StAddr;
          end else if (bus.i_rx_data == CmdRead) begin
            rnw_d   = 1'b1;
            state_d = StAddr;
          end else begin
            resp_d     = DATA_WIDTH'(RspUnk) << (DATA_WIDTH - 8);
            byte_cnt_d = 3'd1;
            state_d    = StResp;
          end
        end
      end
      StAddr: begin
        if (rx_fire) begin
          addr_d = (addr_q << 8) | ADDR_WIDTH'(bus.i_rx_data);
          if (byte_cnt_q == 3'(AB - 1)) begin
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = rnw_q ? StBus : StWdata;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StWdata: begin
        if (rx_fire) begin
          wdata_d = (wdata_q << 8) | DATA_WIDTH'(bus.i_rx_data);
          if (byte_cnt_q == 3'(DB - 1)) begin
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = StBus;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StBus: begin
        // An ack on the final timeout cycle still counts as success.
        if (bus.i_bus_ack) begin
          if (rnw_q) begin
            resp_d     = bus.i_bus_rdata;
            byte_cnt_d = 3'(DB);
          end else begin
            resp_d     = DATA_WIDTH'(RspOk) << (DATA_WIDTH - 8);
            byte_cnt_d = 3'd1;
          end
          state_d = StResp;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          resp_d     = DATA_WIDTH'(RspErr) << (DATA_WIDTH - 8);
          byte_cnt_d = 3'd1;
          state_d    = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      StResp: begin
        if (tx_fire) begin
          resp_d     = resp_q << 8;
          byte_cnt_d = byte_cnt_q - 3'd1;
          if (byte_cnt_q == 3'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    rx_ready_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StWdata);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign bus.o_rx_ready  = rx_ready_q;
  assign bus.o_tx_valid  = (state_q == StResp);
  assign bus.o_tx_data   = resp_q[DATA_WIDTH-1 -: 8];
  assign bus.o_bus_req   = (state_q == StBus);
  assign bus.o_bus_rnw   = rnw_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: frames in, bus responder and TX sink alongside,
// responses compared against hand-computed bytes.
module tb_uart_bus_master;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  uart_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  uart_bus_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bif)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Bus responder: acks on the ack_delay-th cycle of req, records what the bus saw.
  bit          ack_en = 1'b1;
  int          ack_delay = 1;
  logic [31:0] rd_val = '0;
  int          req_run = 0, last_req_len = 0, req_rises = 0, bus_unstable = 0;
  int          stray_req = 0, stray_done = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_rnw = 1'b0;

  initial begin
    bif.i_bus_ack   = 1'b0;
    bif.i_bus_rdata = '0;
    forever begin
      @(negedge clk);
      bif.i_bus_ack = 1'b0;
      if (bif.o_bus_req) begin
        req_run++;
        if (req_run == 1) begin
          req_rises++;
          cap_addr  = bif.o_bus_addr;
          cap_wdata = bif.o_bus_wdata;
          cap_rnw   = bif.o_bus_rnw;
        end else if (bif.o_bus_addr !== cap_addr || bif.o_bus_wdata !== cap_wdata ||
                     bif.o_bus_rnw !== cap_rnw) begin
          bus_unstable++;
        end
        if (ack_en && req_run == ack_delay) begin
          bif.i_bus_ack   = 1'b1;
          bif.i_bus_rdata = rd_val;
        end
      end else begin
        if (req_run > 0) last_req_len = req_run;
        req_run = 0;
        if (stray_req != stray_done) begin
          bif.i_bus_ack   = 1'b1;
          bif.i_bus_rdata = rd_val;
          stray_done      = stray_req;
        end
      end
    end
  end

  // TX sink: holds ready low tx_stall cycles per byte, checks data stays put meanwhile.
  logic [7:0] tx_q[$];
  int         tx_stall = 0, tx_wait = 0, tx_unstable = 0, rx_bad = 0;
  logic [7:0] tx_hold = '0;

  initial begin
    bif.i_tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.o_rx_ready && (bif.o_bus_req || bif.o_tx_valid)) rx_bad++;
      if (bif.o_tx_valid) begin
        if (tx_wait == 0) tx_hold = bif.o_tx_data;
        else if (bif.o_tx_data !== tx_hold) tx_unstable++;
        if (tx_wait >= tx_stall) begin
          bif.i_tx_ready = 1'b1;
          tx_q.push_back(bif.o_tx_data);
          tx_wait = 0;
        end else begin
          bif.i_tx_ready = 1'b0;
          tx_wait++;
        end
      end else begin
        bif.i_tx_ready = 1'b0;
        tx_wait = 0;
      end
    end
  end

  int rx_gap = 0;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat (rx_gap) @(negedge clk);
    bif.i_rx_valid = 1'b1;
    bif.i_rx_data  = b;
    while (!bif.o_rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("rx_accept_timeout", 64'(n), 64'(0));
    @(negedge clk);
    bif.i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (cmd == 8'h57) begin
      for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
    end
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while ((tx_q.size() < n || bif.o_tx_valid || bif.o_bus_req) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check_val("resp_wait_timeout", 64'(tx_q.size()), 64'(n));
  endtask

  task automatic check_resp(input string tag, input int n, input logic [31:0] w);
    logic [7:0] e;
    logic [7:0] g;
    check_val({tag, "_count"}, 64'(tx_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = w[8*(n-1-i) +: 8];
      g = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check_val($sformatf("%s_byte%0d", tag, i), 64'(g), 64'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rx_ready"}, 64'(bif.o_rx_ready), 64'(0));
    check_val({tag, "_tx_valid"}, 64'(bif.o_tx_valid), 64'(0));
    check_val({tag, "_tx_data"},  64'(bif.o_tx_data),  64'(0));
    check_val({tag, "_req"},      64'(bif.o_bus_req),  64'(0));
    check_val({tag, "_rnw"},      64'(bif.o_bus_rnw),  64'(0));
    check_val({tag, "_addr"},     64'(bif.o_bus_addr), 64'(0));
    check_val({tag, "_wdata"},    64'(bif.o_bus_wdata), 64'(0));
  endtask

  int rises_before;

  initial begin
    bif.i_rx_valid = 1'b0;
    bif.i_rx_data  = '0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_val("rx_ready_after_release", 64'(bif.o_rx_ready), 64'(1));

    // Write, ack on third req cycle
    ack_delay = 3;
    tx_q.delete();
    send_frame(8'h57, 32'hC000_0004, 32'hDEAD_BEEF);
    check_val("wr_req_rise", 64'(bif.o_bus_req), 64'(1));
    wait_resp(1);
    check_val("wr_addr", 64'(cap_addr), 64'h0000_0000_C000_0004);
    check_val("wr_wdata", 64'(cap_wdata), 64'h0000_0000_DEAD_BEEF);
    check_val("wr_rnw", 64'(cap_rnw), 64'(0));
    check_val("wr_req_len", 64'(last_req_len), 64'(3));
    check_resp("wr_resp", 1, 32'h4B);

    // Read, immediate ack
    ack_delay = 1;
    rd_val = 32'h1234_5678;
    tx_q.delete();
    send_frame(8'h52, 32'hC000_0008, 32'h0);
    check_val("rd_req_rise", 64'(bif.o_bus_req), 64'(1));
    wait_resp(4);
    check_val("rd_addr", 64'(cap_addr), 64'h0000_0000_C000_0008);
    check_val("rd_rnw", 64'(cap_rnw), 64'(1));
    check_val("rd_wdata_held", 64'(cap_wdata), 64'h0000_0000_DEAD_BEEF);
    check_val("rd_req_len", 64'(last_req_len), 64'(1));
    check_resp("rd_resp", 4, 32'h1234_5678);

    // Timeout, then a stray ack while idle
    ack_en = 1'b0;
    tx_q.delete();
    send_frame(8'h52, 32'h0000_0010, 32'h0);
    wait_resp(1);
    check_val("tmo_req_len", 64'(last_req_len), 64'(TMO));
    check_resp("tmo_resp", 1, 32'h45);
    rises_before = req_rises;
    tx_q.delete();
    stray_req++;
    repeat (10) @(negedge clk);
    check_val("stray_ack_no_tx", 64'(tx_q.size()), 64'(0));
    check_val("stray_ack_no_req", 64'(req_rises), 64'(rises_before));
    check_val("stray_ack_idle", 64'(bif.o_rx_ready), 64'(1));
    ack_en = 1'b1;

    // Unknown command, then a normal read
    rises_before = req_rises;
    tx_q.delete();
    send_byte(8'hAA);
    wait_resp(1);
    check_resp("unk_resp", 1, 32'h3F);
    check_val("unk_no_req", 64'(req_rises), 64'(rises_before));
    rd_val = 32'hA5C3_0F96;
    tx_q.delete();
    send_frame(8'h52, 32'h0000_0020, 32'h0);
    wait_resp(4);
    check_val("unk_next_addr", 64'(cap_addr), 64'h20);
    check_resp("unk_next_resp", 4, 32'hA5C3_0F96);

    // Back-pressure on both streams
    rx_gap = 3;
    tx_stall = 5;
    rd_val = 32'hCAFE_F00D;
    tx_q.delete();
    send_frame(8'h52, 32'h1000_0000, 32'h0);
    wait_resp(4);
    check_val("bp_rd_addr", 64'(cap_addr), 64'h0000_0000_1000_0000);
    check_resp("bp_rd_resp", 4, 32'hCAFE_F00D);
    ack_delay = 2;
    tx_q.delete();
    send_frame(8'h57, 32'h0000_0020, 32'h0102_0304);
    wait_resp(1);
    check_val("bp_wr_wdata", 64'(cap_wdata), 64'h0102_0304);
    check_resp("bp_wr_resp", 1, 32'h4B);
    rx_gap = 0;
    tx_stall = 0;
    ack_delay = 1;

    // Reset mid-address
    tx_q.delete();
    send_byte(8'h52);
    send_byte(8'hC0);
    send_byte(8'h11);
    n_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_addr");
    n_rst = 1'b1;
    @(negedge clk);
    rd_val = 32'h55AA_1234;
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    wait_resp(4);
    check_val("rst_addr_next_addr", 64'(cap_addr), 64'h40);
    check_resp("rst_addr_next_resp", 4, 32'h55AA_1234);

    // Reset mid-transaction
    ack_en = 1'b0;
    tx_q.delete();
    send_frame(8'h57, 32'h0000_0080, 32'hFEED_FACE);
    repeat (4) @(negedge clk);
    check_val("rst_bus_req_before", 64'(bif.o_bus_req), 64'(1));
    n_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_bus");
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("rst_bus_no_resp", 64'(tx_q.size()), 64'(0));
    ack_en = 1'b1;
    rd_val = 32'h0BAD_CAFE;
    send_frame(8'h52, 32'h0000_0044, 32'h0);
    wait_resp(4);
    check_val("rst_bus_next_addr", 64'(cap_addr), 64'h44);
    check_resp("rst_bus_next_resp", 4, 32'h0BAD_CAFE);

    check_val("bus_stable", 64'(bus_unstable), 64'(0));
    check_val("tx_stable", 64'(tx_unstable), 64'(0));
    check_val("rx_ready_busy", 64'(rx_bad), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Byte-stream-driven bus initiator: receives framed read/write commands as bytes from a UART receiver, issues single bus transactions as master, and returns the result as bytes to a UART transmitter. It is the initiating end of the register bus that peripherals such as the UART controller respond on, giving a host PC debug access to the memory map over a serial cable. Sits between the UART byte interfaces and the system bus fabric.

## Interface
- ADDR_WIDTH, 32, bus address width; multiple of 8, 8..32
- DATA_WIDTH, 32, bus data width; multiple of 8, 8..32
- TIMEOUT_CYCLES, 1024, cycles to wait for i_bus_ack before abandoning a transaction; ≥2
- clk  in  1  system clock; single clock domain
- n_rst  in  1  reset, synchronous, active-low
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  i_rx_data valid
- o_rx_ready  out  1  block accepts a byte this cycle
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts the byte this cycle
- o_bus_req  out  1  transaction request
- o_bus_rnw  out  1  1 = read, 0 = write
- o_bus_addr  out  ADDR_WIDTH  transaction address
- o_bus_wdata  out  DATA_WIDTH  write data
- i_bus_ack  in  1  responder completion
- i_bus_rdata  in  DATA_WIDTH  read data, valid when i_bus_ack is high

## Operation
- Byte transfer on either stream occurs when valid and ready are both high on a rising clk edge.
- Frames: 0x57 ('W') + AB address bytes + DB data bytes = write; 0x52 ('R') + AB address bytes = read. AB = ADDR_WIDTH/8, DB = DATA_WIDTH/8. All multi-byte fields big-endian (MSB byte first), shifted in.
- Responses: write OK → one byte 0x4B ('K'); read OK → DB bytes of read data, MSB first; timeout (read or write) → one byte 0x45 ('E'); unknown command byte → one byte 0x3F ('?').
- States: IDLE (await command byte) → ADDR (count AB bytes) → WDATA (count DB bytes, writes only) → BUS (req asserted) → RESP (send response bytes) → IDLE. IDLE on unknown command → RESP with '?'.
- o_rx_ready high only in IDLE, ADDR, WDATA. No bytes are consumed in BUS or RESP; upstream back-pressures.
- In BUS: o_bus_req, o_bus_rnw, o_bus_addr, o_bus_wdata held stable until i_bus_ack sampled high or timeout. On ack, read data captured into the response shift register.
- Timeout counter starts at 0 on entering BUS, increments per cycle without ack; when it reaches TIMEOUT_CYCLES-1 without ack, req drops and the 'E' response is sent. Ack in the same cycle as the final count wins (success).
- o_bus_wdata is don't-care-but-stable for reads (holds last write value).
- RESP: o_tx_valid held high with o_tx_data stable until accepted; next byte presented the cycle after acceptance; after the last byte, IDLE.
- No inter-byte timeout on the receive side; a partial frame waits indefinitely.

## Timing
- Reset (n_rst low at clk edge): state IDLE, counters 0, o_rx_ready 0 during reset then 1 the first cycle after release; o_tx_valid 0, o_tx_data 0x00, o_bus_req 0, o_bus_rnw 0, o_bus_addr 0, o_bus_wdata 0. Reset mid-frame or mid-transaction aborts with no response; o_bus_req drops the cycle reset is sampled.
- o_bus_req rises the cycle after the final frame byte is accepted.
- o_bus_req falls the cycle after i_bus_ack is sampled high (one-cycle ack pulse expected; ack is ignored outside BUS).
- First o_tx_valid rises the cycle after ack/timeout/unknown-command detection.
- Minimum read round trip with immediate ack and always-ready TX: last address byte at cycle N, req N+1, ack N+1, first response byte valid N+2, last byte accepted N+1+DB.

## Test plan
- Write: feed 57 C0 00 00 04 DE AD BE EF, ack 3 cycles after req → bus sees addr 0xC0000004, wdata 0xDEADBEEF, rnw 0, req held 3 cycles; TX emits 0x4B.
- Read: feed 52 C0 00 00 08, ack with rdata 0x12345678 → rnw 1; TX emits 12 34 56 78 in order; o_rx_ready low until final byte accepted.
- Timeout: TIMEOUT_CYCLES=16, read with no ack → req high exactly 16 cycles then low; TX emits 0x45; late ack afterwards ignored.
- Unknown command 0xAA → TX emits 0x3F, no o_bus_req; following valid read frame completes normally.
- Back-pressure: i_tx_ready low 5 cycles per byte and i_rx_valid gaps → o_tx_data stable while valid, no byte lost or duplicated.
- Reset asserted mid-BUS and mid-ADDR → all outputs at reset values next cycle; no response emitted; subsequent frame decoded from a clean IDLE.
